pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//   Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) for the miniRV pipeline.
//   Generalises the fixed-field stage register with parametrised data/control widths, a valid bit,
//   a valid/ready handshake, hazard-unit stall (hold) and flush (bubble insertion), and a bubble counter.
// PARAMETERS
//   DATA_W    192    data payload width (rD1, rD2, pc, pc4, imm, ... concatenated)
//   CTRL_W    17     control payload width (wR, rf_wsel, br, rf_we, alu_op, alub_sel, ram_we)
//   NOP_CTRL  '0     control value held while bubble/reset; must have all write-enables = 0
//   CNT_W     16     width of bubble counter
// PORTS
//   clk_i        in   1       clock
//   rst_i        in   1       reset, asynchronous, active-high
//   in_valid_i   in   1       upstream beat valid
//   in_ready_o   out  1       stage can accept a beat this cycle
//   in_data_i    in   DATA_W  upstream data payload
//   in_ctrl_i    in   CTRL_W  upstream control payload
//   stall_i      in   1       hazard-unit hold: freeze stage contents
//   flush_i      in   1       hazard-unit kill: discard stored and incoming beats
//   out_valid_o  out  1       stage holds a valid beat
//   out_ready_i  in   1       downstream accepts beat
//   out_data_o   out  DATA_W  registered data payload
//   out_ctrl_o   out  CTRL_W  registered control payload; NOP_CTRL whenever not valid
//   bubble_cnt_o out  CNT_W   count of cycles with out_valid_o=0 since reset, saturating
// BEHAVIOUR
//   - Reset (async, any time, incl. mid-transfer): valid=0, out_data_o=0, out_ctrl_o=NOP_CTRL,
//     bubble_cnt_o=0; skid entry (if present) emptied. All outputs from flops except in_ready_o, out_valid_o.
//   - out_valid_o = valid_q & ~stall_i. in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
//   - Latency: 1 cycle in->out when no stall/backpressure. Full throughput (1 beat/cycle) when out_ready_i=1.
//   - Priority per edge: flush_i > stall_i > normal handshake.
//   - flush_i=1: next edge valid=0, out_ctrl_o=NOP_CTRL, out_data_o unchanged; in_ready_o=1 and any
//     incoming beat is consumed and dropped; skid emptied. Flush wins over simultaneous stall.
//   - stall_i=1 (no flush): in_ready_o=0, no out_fire, all state held bit-exact.
//   - Normal: if out_fire or ~valid_q, load next beat (in_fire -> payload, valid=1; else valid=0,
//     ctrl=NOP_CTRL). If valid_q & ~out_ready_i, hold.
//   - Control is never exposed for an invalid beat: out_ctrl_o=NOP_CTRL whenever valid_q=0.
//   - bubble_cnt_o increments on every edge where out_valid_o=0, holds at 2^CNT_W-1 (no wrap).
// CONFIGURATION
//   PIPE_SKID_EN defined: 2-entry stage (main + skid). in_ready_o = ~skid_valid_q & ~stall_i (| flush_i),
//     i.e. no combinational path out_ready_i -> in_ready_o. Beat arriving while main is valid and
//     not draining goes to skid; skid moves to main on out_fire; order strictly preserved.
//   PIPE_SKID_EN undefined: 1-entry stage. in_ready_o = ((~valid_q | out_ready_i) & ~stall_i) | flush_i.
//   Cycle-level behaviour with out_ready_i tied 1 is identical in both builds.
// STRUCTURE
//   Package pipe_pkg: ctrl field widths, packed ctrl_t struct typedef, NOP_CTRL constant,
//     default DATA_W/CTRL_W per stage (IFID/IDEX/EXMEM/MEMWB).
//   Sub-module pipe_skid_buf (1-entry bypass buffer), instantiated only under PIPE_SKID_EN.
//   Bubble counter inline (saturating incrementer).
// TESTING
//   1. Reset mid-stream: 3 valid beats, assert rst_i between edges -> out_valid_o=0, ctrl=NOP_CTRL,
//      bubble_cnt_o=0 immediately (async).
//   2. Streaming: beats D=1..8, out_ready_i=1 -> each appears exactly 1 cycle later, no gaps, bubble_cnt_o frozen.
//   3. Stall: beat 0xA5 in stage, stall_i=1 for 4 cycles -> out_valid_o=0, in_ready_o=0, payload held,
//      bubble_cnt_o +4; release -> 0xA5 delivered once.
//   4. Flush+stall same cycle with in_valid_i=1 beat 0x3C -> next cycle valid=0, ctrl=NOP_CTRL, 0x3C never emitted.
//   5. Backpressure: out_ready_i=0 for 3 cycles, in_valid_i=1 -> single-entry: in_ready_o=0, skid: exactly one
//      extra beat accepted; order 1,2,3 preserved on release.
//   6. Saturation with CNT_W=4: hold idle 20 cycles -> bubble_cnt_o=15, stays 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the miniRV inter-stage pipeline registers.
// Control field layout, the default no-op control word and per-stage payload widths.
package pipe_pkg;

  localparam int WR_W       = 5;
  localparam int RF_WSEL_W  = 2;
  localparam int BR_W       = 3;
  localparam int RF_WE_W    = 1;
  localparam int ALU_OP_W   = 4;
  localparam int ALUB_SEL_W = 1;
  localparam int RAM_WE_W   = 1;

  localparam int CTRL_W_DEF = WR_W + RF_WSEL_W + BR_W + RF_WE_W +
                              ALU_OP_W + ALUB_SEL_W + RAM_WE_W;

  typedef struct packed {
    logic [WR_W-1:0]       wr;
    logic [RF_WSEL_W-1:0]  rf_wsel;
    logic [BR_W-1:0]       br;
    logic [RF_WE_W-1:0]    rf_we;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [ALUB_SEL_W-1:0] alub_sel;
    logic [RAM_WE_W-1:0]   ram_we;
  } ctrl_t;

  // All write-enables low: safe to hold while the stage carries a bubble.
  localparam ctrl_t NOP_CTRL_DEF = '0;

  // Default payload widths per stage boundary.
  localparam int IFID_DATA_W  = 96;
  localparam int IFID_CTRL_W  = CTRL_W_DEF;
  localparam int IDEX_DATA_W  = 192;
  localparam int IDEX_CTRL_W  = CTRL_W_DEF;
  localparam int EXMEM_DATA_W = 160;
  localparam int EXMEM_CTRL_W = CTRL_W_DEF;
  localparam int MEMWB_DATA_W = 128;
  localparam int MEMWB_CTRL_W = CTRL_W_DEF;

endpackage

// File: rtl/pipe_stage_reg_skid.sv
// pipe_skid_buf: single-entry bypass buffer used as the second slot of a pipeline stage.
// When empty the outputs pass the incoming beat straight through, so the consumer
// always reads "oldest available beat" from one place.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = IDEX_DATA_W,
  parameter int                CTRL_W   = IDEX_CTRL_W,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Entry storage: clear beats push beats beats pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= NOP_CTRL;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      ctrl_q  <= ctrl_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = valid_q ? data_q : data_i;
  assign ctrl_o  = valid_q ? ctrl_q : ctrl_i;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with valid/ready handshake,
// hazard stall/flush and a saturating bubble counter.
// Build option: define PIPE_SKID_EN for a 2-entry stage (main + skid) that breaks the
// combinational out_ready_i -> in_ready_o path; otherwise a 1-entry stage.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = IDEX_DATA_W,
  parameter int                CTRL_W   = IDEX_CTRL_W,
  parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(NOP_CTRL_DEF),
  parameter int                CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              in_fire;
  logic              out_fire;
  logic              load_main;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic [CTRL_W-1:0] src_ctrl;

  assign out_valid_o = valid_q & ~stall_i;
  assign out_fire    = out_valid_o & out_ready_i;
  assign in_fire     = in_valid_i & in_ready_o;

  // Main slot takes a new beat (or goes empty) when it is empty or draining this cycle.
  assign load_main   = ~flush_i & ~stall_i & (~valid_q | out_fire);

`ifdef PIPE_SKID_EN
  logic skid_valid;
  logic skid_push;
  logic skid_pop;

  // A beat that cannot enter main (main full and not draining) parks in the skid entry.
  assign skid_push  = in_fire & ~flush_i & ~load_main;
  assign skid_pop   = load_main & skid_valid;
  assign in_ready_o = (~skid_valid & ~stall_i) | flush_i;
  // Skid holds the older beat, so it has priority; its bypass mux hands over in_data otherwise.
  assign src_valid  = skid_valid | in_fire;

  pipe_skid_buf #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .NOP_CTRL (NOP_CTRL)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (flush_i),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .data_i  (in_data_i),
    .ctrl_i  (in_ctrl_i),
    .valid_o (skid_valid),
    .data_o  (src_data),
    .ctrl_o  (src_ctrl)
  );
`else
  assign in_ready_o = ((~valid_q | out_ready_i) & ~stall_i) | flush_i;
  assign src_valid  = in_fire;
  assign src_data   = in_data_i;
  assign src_ctrl   = in_ctrl_i;
`endif

  // Main slot: flush kills the beat but leaves data untouched; control drops to NOP when empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= NOP_CTRL;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= NOP_CTRL;
    end else if (load_main) begin
      if (src_valid) begin
        valid_q <= 1'b1;
        data_q  <= src_data;
        ctrl_q  <= src_ctrl;
      end else begin
        valid_q <= 1'b0;
        ctrl_q  <= NOP_CTRL;
      end
    end
  end

  // Bubble counter: one count per edge without a visible beat, sticks at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (~out_valid_o && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_data_o   = data_q;
  assign out_ctrl_o   = ctrl_q;
  assign bubble_cnt_o = cnt_q;

endmodule
